// File: rtl/rca_mpadd_seq.sv
// rca_mpadd_seq: word-serial multi-precision adder reusing one N-bit ripple-carry adder over WORDS cycles.
// Optional subtract mode (port sub) is built when RCA_SUB_EN is defined.
module rca_mpadd_seq_rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_s,
  output logic         o_cout
);
  logic [N:0] w_c;
  assign w_c[0] = i_cin;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign o_s[i]    = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end
  assign o_cout = w_c[N];
endmodule

module rca_mpadd_seq #(
  parameter int N     = 8,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
`ifdef RCA_SUB_EN
  input  logic               sub,
`endif
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] sum,
  output logic               cout
);
  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        r_state, w_next;
  logic [W-1:0]  r_a, r_b, r_sum;
  logic [IW-1:0] r_idx;
  logic          r_carry, r_cout;
  logic [N-1:0]  w_a_word, w_b_word, w_s;
  logic          w_co, w_accept, w_init_carry;
`ifdef RCA_SUB_EN
  logic r_sub;
  assign w_b_word     = r_b[r_idx*N +: N] ^ {N{r_sub}};
  assign w_init_carry = sub | cin;
`else
  assign w_b_word     = r_b[r_idx*N +: N];
  assign w_init_carry = cin;
`endif
  assign w_a_word = r_a[r_idx*N +: N];
  assign w_accept = (r_state == IDLE) && start;
  rca_mpadd_seq_rca #(.N(N)) u_rca (
    .i_a    (w_a_word),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_co)
  );
  always_comb begin
    w_next = (r_state == IDLE) ? (start ? RUN : IDLE) :
             (r_state == RUN)  ? ((r_idx == LAST) ? DONE : RUN) : IDLE;
    busy   = r_state != IDLE;
    done   = r_state == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
`ifdef RCA_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= w_init_carry;
        r_idx   <= '0;
        r_sum   <= '0;
        r_cout  <= 1'b0;
`ifdef RCA_SUB_EN
        r_sub   <= sub;
`endif
      end else if (r_state == RUN) begin
        r_sum[r_idx*N +: N] <= w_s;
        r_carry             <= w_co;
        if (r_idx == LAST) r_cout <= w_co;
        else r_idx <= r_idx + IW'(1);
      end
    end
  end
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_rca_mpadd_seq.sv
// tb_rca_mpadd_seq: vector table, hand-written handshake/reset sequences and random ops against an arithmetic model.
module tb_rca_mpadd_seq;
  localparam int N = 8, WORDS = 4, W = N * WORDS;
  logic clk = 0, rst = 1, start = 0, cin = 0, sub = 0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, cout;
  logic [W-1:0] sum;
  int checks = 0, errors = 0;
  typedef struct {
    logic [W-1:0] a, b;
    logic cin, sub;
    logic [W-1:0] s;
    logic co;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  rca_mpadd_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef RCA_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, y, input logic c, s);
    if (s) return {x >= y, x - y};
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  // Expects IDLE on entry; returns one cycle after done, back in IDLE.
  task automatic run_op(input string name, input logic [W-1:0] va, vb, input logic vc, vs,
                        input bit scramble, input logic [W-1:0] es, input logic eco);
    int lat = 0;
    a = va; b = vb; cin = vc; sub = vs; start = 1;
    @(posedge clk); #1 start = 0;
    chk({name, " busy"}, busy, 1);
    while (!done && lat < 20) begin
      if (scramble) begin a = $urandom; b = $urandom; cin = 1'($urandom); end
      @(posedge clk); #1 lat++;
    end
    chk({name, " latency"}, lat, WORDS);
    chk({name, " sum"}, sum, es);
    chk({name, " cout"}, cout, eco);
    @(posedge clk); #1;
    chk({name, " done pulse"}, done, 0);
    chk({name, " busy end"}, busy, 0);
    chk({name, " sum hold"}, sum, es);
  endtask

  initial begin
    logic [W:0] m;
    bit seen;
    tbl.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0});
    tbl.push_back('{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0});
    tbl.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
    tbl.push_back('{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0});
    tbl.push_back('{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0, 32'h0000_0000, 1'b1});
`ifdef RCA_SUB_EN
    tbl.push_back('{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0});
    tbl.push_back('{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1});
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("idle no start", busy, 0);
    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 0, tbl[i].s, tbl[i].co);

    // start arriving mid-RUN and held through DONE must wait for IDLE
    a = 32'h1; b = 32'h1; cin = 0; sub = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (2) @(posedge clk);
    #1 a = 32'h10; b = 32'h10; start = 1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin @(posedge clk); #1 seen = done; end
    chk("busy-start done", seen, 1);
    chk("busy-start sum", sum, 32'h2);
    chk("busy-start cout", cout, 0);
    @(posedge clk); #1;
    chk("busy-start idle", busy, 0);
    chk("busy-start sum kept", sum, 32'h2);
    @(posedge clk); #1 start = 0;
    chk("busy-start accepted", busy, 1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin @(posedge clk); #1 seen = done; end
    chk("second done", seen, 1);
    chk("second sum", sum, 32'h20);
    @(posedge clk); #1;

    // asynchronous reset in the middle of RUN
    a = 32'h1234_5678; b = 32'h1111_1111; start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1;
    chk("partial word0", sum[7:0], 8'h89);
    rst = 1;
    #1;
    chk("midrst sum", sum, 0);
    chk("midrst cout", cout, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    @(posedge clk); #1 rst = 0;
    seen = 0;
    repeat (8) begin @(posedge clk); #1 seen |= done; end
    chk("no done after reset", seen, 0);
    run_op("after reset", 32'h1234_5678, 32'h1111_1111, 0, 0, 0, 32'h2345_6789, 0);

    run_op("stability", 32'h3, 32'h4, 0, 0, 1, 32'h7, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rs;
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
`ifdef RCA_SUB_EN
      rs = 1'($urandom);
`else
      rs = 0;
`endif
      if (i % 8 == 0) rb = ~ra;
      m = model(ra, rb, rc, rs);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, i % 3 == 0, m[W-1:0], m[W]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
